// File: rtl/padd_sat_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : padd_sat_pipe_if
// Purpose  : Bundles the operand/result handshake signals of the packed
//            saturating lane adder/subtractor.
// Ports    : in_valid/in_ready/a/b/op  - operand beat (master -> slave)
//            out_valid/out_ready/sum/ovf - result beat (slave -> master)
//            ovf_sticky/clr_ovf          - accumulated overflow status
// Revision : 1.0 - initial release
// ============================================================================
interface padd_sat_pipe_if #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
);
    localparam int c_w = LANE_W * LANES;

    logic             in_valid;
    logic             in_ready;
    logic [c_w-1:0]   a;
    logic [c_w-1:0]   b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [c_w-1:0]   sum;
    logic [LANES-1:0] ovf;
    logic [LANES-1:0] ovf_sticky;
    logic             clr_ovf;

    // Producer/consumer side (testbench or surrounding datapath).
    modport master (
        output in_valid, a, b, op, out_ready, clr_ovf,
        input  in_ready, out_valid, sum, ovf, ovf_sticky
    );

    // Arithmetic unit side.
    modport slave (
        input  in_valid, a, b, op, out_ready, clr_ovf,
        output in_ready, out_valid, sum, ovf, ovf_sticky
    );
endinterface
`default_nettype wire

// File: rtl/padd_sat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : padd_sat_pipe
// Purpose  : Two-stage valid/ready pipelined SIMD lane adder/subtractor with
//            per-lane signed saturation or wrap-around and sticky per-lane
//            overflow status.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - padd_sat_pipe_if.slave (operands, op, results, status)
// Revision : 1.0 - initial release
// ============================================================================
module padd_sat_pipe #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    padd_sat_pipe_if.slave       bus
);
    localparam int c_w = LANE_W * LANES;

    // Stage 1: raw lane results and what S2 needs to saturate them.
    logic             r_s1_valid;
    logic [c_w-1:0]   r_s1_raw;
    logic [LANES-1:0] r_s1_ovf;
    logic [LANES-1:0] r_s1_sgn;
    logic             r_s1_wrap;

    // Stage 2: output register.
    logic             r_out_valid;
    logic [c_w-1:0]   r_sum;
    logic [LANES-1:0] r_ovf;
    logic [LANES-1:0] r_ovf_sticky;

    logic [c_w-1:0]   w_raw;
    logic [LANES-1:0] w_ovf;
    logic [LANES-1:0] w_sgn;
    logic [c_w-1:0]   w_sat;
    logic             w_s1_en;
    logic             w_s2_en;
    logic             w_s2_load;

    // Ready chain depends only on state and out_ready, never on in_valid.
    assign w_s2_en   = ~r_out_valid | bus.out_ready;
    assign w_s1_en   = ~r_s1_valid | w_s2_en;
    assign w_s2_load = w_s2_en & r_s1_valid;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LANE_W-1:0] w_a;
        logic [LANE_W-1:0] w_b;
        logic [LANE_W-1:0] w_bx;
        logic [LANE_W-1:0] w_r;
        logic [LANE_W-1:0] w_lim;

        assign w_a  = bus.a[gi*LANE_W +: LANE_W];
        assign w_b  = bus.b[gi*LANE_W +: LANE_W];
        // Subtraction as a + ~b + 1; carry-in is the op bit itself.
        assign w_bx = bus.op[0] ? ~w_b : w_b;
        assign w_r  = w_a + w_bx + {{(LANE_W-1){1'b0}}, bus.op[0]};

        // With b inverted for subtract, both add and sub overflow reduce to:
        // operands share a sign and the result sign differs from it.
        assign w_ovf[gi] = (w_a[LANE_W-1] == w_bx[LANE_W-1]) &&
                           (w_r[LANE_W-1] != w_a[LANE_W-1]);
        assign w_sgn[gi] = w_a[LANE_W-1];
        assign w_raw[gi*LANE_W +: LANE_W] = w_r;

        // Clamp toward the sign of a: 0111..1 for positive, 1000..0 for negative.
        assign w_lim = {r_s1_sgn[gi], {(LANE_W-1){~r_s1_sgn[gi]}}};
        assign w_sat[gi*LANE_W +: LANE_W] =
            (r_s1_ovf[gi] & ~r_s1_wrap) ? w_lim : r_s1_raw[gi*LANE_W +: LANE_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_raw   <= '0;
            r_s1_ovf   <= '0;
            r_s1_sgn   <= '0;
            r_s1_wrap  <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_raw  <= w_raw;
                r_s1_ovf  <= w_ovf;
                r_s1_sgn  <= w_sgn;
                r_s1_wrap <= bus.op[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_sum        <= '0;
            r_ovf        <= '0;
            r_ovf_sticky <= '0;
        end else begin
            if (w_s2_en) begin
                r_out_valid <= r_s1_valid;
            end
            if (w_s2_load) begin
                r_sum <= w_sat;
                r_ovf <= r_s1_ovf;
                // A clear that coincides with a load keeps the new event.
                r_ovf_sticky <= bus.clr_ovf ? r_s1_ovf : (r_ovf_sticky | r_s1_ovf);
            end else if (bus.clr_ovf) begin
                r_ovf_sticky <= '0;
            end
        end
    end

    assign bus.in_ready   = w_s1_en;
    assign bus.out_valid  = r_out_valid;
    assign bus.sum        = r_sum;
    assign bus.ovf        = r_ovf;
    assign bus.ovf_sticky = r_ovf_sticky;
endmodule
`default_nettype wire

// File: tb/tb_padd_sat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_padd_sat_pipe
// Purpose  : Directed self-checking bench for padd_sat_pipe, exercising a
//            4x4-bit and a 2x8-bit configuration side by side.
// Ports    : none (top level)
// Revision : 1.0 - initial release
// ============================================================================
module tb_padd_sat_pipe;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    padd_sat_pipe_if #(.LANE_W(4), .LANES(4)) bus4 ();
    padd_sat_pipe_if #(.LANE_W(8), .LANES(2)) bus8 ();

    padd_sat_pipe #(.LANE_W(4), .LANES(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    padd_sat_pipe #(.LANE_W(8), .LANES(2)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single beat through an idle 4x4 pipeline with out_ready high.
    task automatic beat4(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [15:0] es, input logic [3:0] eo);
        bus4.a         = a;
        bus4.b         = b;
        bus4.op        = op;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(bus4.in_ready), 32'd1);
        tick;
        bus4.in_valid = 1'b0;
        chk({tag, "_valid_n1"}, 32'(bus4.out_valid), 32'd0);
        tick;
        chk({tag, "_valid_n2"}, 32'(bus4.out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(bus4.sum), 32'(es));
        chk({tag, "_ovf"}, 32'(bus4.ovf), 32'(eo));
    endtask

    task automatic beat8(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [15:0] es, input logic [1:0] eo);
        bus8.a         = a;
        bus8.b         = b;
        bus8.op        = op;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        tick;
        bus8.in_valid = 1'b0;
        tick;
        chk({tag, "_valid"}, 32'(bus8.out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(bus8.sum), 32'(es));
        chk({tag, "_ovf"}, 32'(bus8.ovf), 32'(eo));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst            = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.a         = '0;
        bus4.b         = '0;
        bus4.op        = 2'b00;
        bus4.out_ready = 1'b1;
        bus4.clr_ovf   = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.op        = 2'b00;
        bus8.out_ready = 1'b1;
        bus8.clr_ovf   = 1'b0;
        repeat (3) tick;
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_sum", 32'(bus4.sum), 32'd0);
        chk("rst_ovf", 32'(bus4.ovf), 32'd0);
        chk("rst_sticky", 32'(bus4.ovf_sticky), 32'd0);
        chk("rst_in_ready", 32'(bus4.in_ready), 32'd1);

        // Add saturate, then add wrap on the same operands
        beat4("add_sat", 16'h7281, 16'h1F38, 2'b00, 16'h71B9, 4'b1000);
        beat4("add_wrap", 16'h7281, 16'h1F38, 2'b10, 16'h81B9, 4'b1000);
        chk("sticky_add", 32'(bus4.ovf_sticky), 32'h8);

        // Standalone clear
        bus4.clr_ovf = 1'b1;
        tick;
        bus4.clr_ovf = 1'b0;
        chk("sticky_clr", 32'(bus4.ovf_sticky), 32'h0);

        // Subtract saturate at both extremes
        beat4("sub_neg", 16'h8000, 16'h1000, 2'b01, 16'h8000, 4'b1000);
        beat4("sub_pos", 16'h0000, 16'h0008, 2'b01, 16'h0007, 4'b0001);
        chk("sticky_sub", 32'(bus4.ovf_sticky), 32'h9);
        tick;
        chk("drain_valid", 32'(bus4.out_valid), 32'd0);

        // Backpressure: three beats with out_ready low
        bus4.out_ready = 1'b0;
        bus4.op        = 2'b00;
        bus4.in_valid  = 1'b1;
        bus4.a = 16'h0001; bus4.b = 16'h0001;
        #1;
        chk("bp_rdy1", 32'(bus4.in_ready), 32'd1);
        tick;
        bus4.a = 16'h0002; bus4.b = 16'h0001;
        #1;
        chk("bp_rdy2", 32'(bus4.in_ready), 32'd1);
        tick;
        bus4.a = 16'h0004; bus4.b = 16'h0001;
        #1;
        chk("bp_rdy3", 32'(bus4.in_ready), 32'd0);
        chk("bp_v1", 32'(bus4.out_valid), 32'd1);
        chk("bp_sum1", 32'(bus4.sum), 32'h0002);
        // Operand change while stalled must not disturb anything
        tick;
        chk("bp_hold_sum", 32'(bus4.sum), 32'h0002);
        chk("bp_hold_rdy", 32'(bus4.in_ready), 32'd0);
        bus4.out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(bus4.in_ready), 32'd1);
        tick;
        bus4.in_valid = 1'b0;
        chk("bp_v2", 32'(bus4.out_valid), 32'd1);
        chk("bp_sum2", 32'(bus4.sum), 32'h0003);
        tick;
        chk("bp_v3", 32'(bus4.out_valid), 32'd1);
        chk("bp_sum3", 32'(bus4.sum), 32'h0005);
        tick;
        chk("bp_drain", 32'(bus4.out_valid), 32'd0);
        chk("bp_sticky", 32'(bus4.ovf_sticky), 32'h9);

        // Clear coinciding with an S2 load keeps the new event
        bus4.a = 16'h0070; bus4.b = 16'h0010; bus4.op = 2'b00;
        bus4.in_valid = 1'b1;
        tick;
        bus4.in_valid = 1'b0;
        bus4.clr_ovf  = 1'b1;
        tick;
        chk("clr_load_sticky", 32'(bus4.ovf_sticky), 32'h2);
        chk("clr_load_ovf", 32'(bus4.ovf), 32'h2);
        chk("clr_load_sum", 32'(bus4.sum), 32'h0070);
        tick;
        bus4.clr_ovf = 1'b0;
        chk("clr_alone_sticky", 32'(bus4.ovf_sticky), 32'h0);

        // Reset with two beats in flight
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.a = 16'h0001; bus4.b = 16'h0001;
        tick;
        bus4.a = 16'h0002;
        tick;
        bus4.in_valid = 1'b0;
        chk("inflight_valid", 32'(bus4.out_valid), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_valid", 32'(bus4.out_valid), 32'd0);
        chk("midrst_sum", 32'(bus4.sum), 32'd0);
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("midrst_no_out", 32'(bus4.out_valid), 32'd0);
        end

        // 2x8-bit configuration
        beat8("w8_add", 16'h7F80, 16'h0101, 2'b00, 16'h7F81, 2'b10);
        beat8("w8_sub", 16'h7F80, 16'h0101, 2'b01, 16'h7E80, 2'b01);
        chk("w8_sticky", 32'(bus8.ovf_sticky), 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/padd_sat_pipe.md
# padd_sat_pipe

Parametrised, pipelined SIMD lane adder/subtractor with per-lane signed saturation or wrap-around and sticky per-lane overflow status. Generalises the fixed 16-bit, 4×4-bit saturating adder to any lane width and lane count. Adds subtraction, a non-saturating mode, a 2-stage valid/ready pipeline and overflow reporting. Sits in the execute path as the packed-arithmetic unit.

## Interface
- LANE_W, 4, bits per lane (≥2); each lane is a two's-complement integer
- LANES, 4, number of lanes (≥1); W = LANE_W*LANES
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  unit accepts the beat this cycle
- a  in  W  operand A; lane i = a[i*LANE_W +: LANE_W]
- b  in  W  operand B, same packing
- op  in  2  op[0]: 0 = A+B, 1 = A−B; op[1]: 0 = saturate, 1 = wrap
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- sum  out  W  packed per-lane result
- ovf  out  LANES  per-lane overflow flags of the current result, raw even in wrap mode
- ovf_sticky  out  LANES  per-lane OR of ovf over all results loaded since reset or clear
- clr_ovf  in  1  clears ovf_sticky

## Operation
- Lanes are fully independent; no carry crosses a lane boundary.
- Per lane, in LANE_W bits: r = a + b (add) or r = a + ~b + 1 (sub).
- Add overflow: sign(a) == sign(b) and sign(r) != sign(a).
- Sub overflow: sign(a) != sign(b) and sign(r) != sign(a).
- Saturate mode: on overflow, the lane is 0111…1 if sign(a)=0, else 1000…0; otherwise r.
- Wrap mode: the lane is r (low LANE_W bits); ovf still reports the overflow.
- Stage 1 (S1) registers raw r, per-lane overflow bits, a's sign bits, op[1] and valid.
- Stage 2 (S2, output register) applies saturation and drives sum, ovf and out_valid.
- ovf_sticky |= ovf_next whenever S2 loads a valid beat.
- clr_ovf clears ovf_sticky. If clr_ovf coincides with an S2 load, the result is ovf_next, so the new event is kept.

## Timing
- Reset: out_valid=0, S1 valid=0, sum=0, ovf=0, ovf_sticky=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation drops both in-flight beats; no output handshake occurs for them.
- s2_en = ~out_valid | out_ready.
- s1_en = ~s1_valid | s2_en.
- in_ready = s1_en, combinational from out_ready and state; there is no path from in_valid to in_ready.
- An input is accepted when in_valid & in_ready. An output is consumed when out_valid & out_ready.
- Latency: a beat accepted in cycle N appears on out_valid in cycle N+2 if there is no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: while out_valid & ~out_ready, sum, ovf and out_valid hold stable. S1 still accepts one beat if it is empty, then in_ready=0.
- Simultaneous output consume and input accept in a full pipeline: all stages advance the same cycle, with no bubble.
- op, a and b are sampled only at acceptance; changes on them while in_ready=0 have no effect.

## Test plan
- LANE_W=4, LANES=4, a=16'h7281, b=16'h1F38, op=00 → sum=16'h71B9, ovf=4'b1000, out_valid exactly 2 cycles after acceptance.
- Same operands, op=10 (add, wrap) → sum=16'h81B9, ovf=4'b1000; ovf_sticky=4'b1000 after both beats.
- op=01 (sub, saturate): a=16'h8000, b=16'h1000 → 16'h8000, ovf=4'b1000. Then a=16'h0000, b=16'h0008 → 16'h0007, ovf=4'b0001; ovf_sticky=4'b1001.
- Backpressure: 3 back-to-back beats with out_ready=0 → in_ready=0 from the 3rd cycle, and sum stays fixed at beat 1. Then raise out_ready → beats 1, 2, 3 appear in order on consecutive cycles with none lost or duplicated.
- clr_ovf in the same cycle S2 loads a beat with ovf=4'b0010 → ovf_sticky=4'b0010. clr_ovf alone next cycle → 0. Assert rst with 2 beats in flight → out_valid=0 the next cycle and no output handshake.
- LANE_W=8, LANES=2: a=16'h7F80, b=16'h0101, op=00 → sum=16'h7F81, ovf=2'b10. With op=01 → sum=16'h7E80 (0x80−1 saturates to 0x80), ovf=2'b01.
